// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single RGB tile ROM between the background fetcher (port 0)
// and the sprite/ball fetcher (port 1), one outstanding read at a time, round-robin.
module rom_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_valid0,
    output logic              o_valid1,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_rom_read,
    output logic [ADDR_W-1:0] o_rom_address,
    input  logic [DATA_W-1:0] i_rom_data,
    input  logic              i_rom_valid
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid0_q, valid0_d;
    logic              valid1_q, valid1_d;
    logic              err_q, err_d;
    logic              winner;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            port_q   <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            port_q   <= port_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            err_q    <= err_d;
        end
    end

    // The response strobes are pulses, so they default low; everything else holds.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        port_d   = port_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        err_d    = 1'b0;
        winner   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    winner  = (i_req0 && i_req1) ? rr_q : i_req1;
                    port_d  = winner;
                    rr_d    = ~winner;
                    addr_d  = winner ? i_addr1 : i_addr0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A ROM answer in the last allowed cycle still beats the timeout.
                if (i_rom_valid) begin
                    data_d   = i_rom_data;
                    valid0_d = ~port_q;
                    valid1_d = port_q;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d   = '0;
                    valid0_d = ~port_q;
                    valid1_d = port_q;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_gnt0        = (state_q == ISSUE) && !port_q;
    assign o_gnt1        = (state_q == ISSUE) && port_q;
    assign o_rom_read    = (state_q == ISSUE);
    assign o_busy        = (state_q != IDLE);
    assign o_rom_address = addr_q;
    assign o_data        = data_q;
    assign o_valid0      = valid0_q;
    assign o_valid1      = valid1_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: drives both requesters and a ROM model, predicting every output
// from a transaction-level schedule (grant, read, response cycles) of each access.
module tb_rom_arbiter;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 24;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic              romValid = 1'b0;
    logic [DATA_W-1:0] romData = '0;
    logic              gnt0, gnt1, valid0, valid1, err, busy, romRead;
    logic [ADDR_W-1:0] romAddress;
    logic [DATA_W-1:0] data;

    rom_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_addr0      (addr0),
        .i_addr1      (addr1),
        .o_gnt0       (gnt0),
        .o_gnt1       (gnt1),
        .o_valid0     (valid0),
        .o_valid1     (valid1),
        .o_data       (data),
        .o_err        (err),
        .o_busy       (busy),
        .o_rom_read   (romRead),
        .o_rom_address(romAddress),
        .i_rom_data   (romData),
        .i_rom_valid  (romValid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction schedule: cycle numbers of the current access, -1 when none.
    int              cyc, rr, freeAt, winner, readCyc, respCyc, romValidCyc, lateValidCyc, quietUntil;
    int              waitResets;
    logic [8:0]      wAddr;
    logic [23:0]     expData, lastData;
    bit              expErr, addrZeroCheck;
    bit              active[2];
    logic [8:0]      reqAddr[2];
    int              reqProb[2], fixAddr[2];
    int              forceLat, strayProb, resetProb;
    bit              lateInject;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
        end
    endtask

    function automatic logic [23:0] romWord(input logic [8:0] a);
        if (a == 9'h015) return 24'hFF8000;
        return {a[7:0] ^ 8'h5A, a[8:1] + 8'h33, ~a[7:0]};
    endfunction

    function automatic int pickLat();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 10) return TIMEOUT;
        if (r < 18) return TIMEOUT - 1;
        return int'($urandom_range(1, 6));
    endfunction

    task automatic setPhase(input int p0, input int p1, input int a0, input int a1,
                            input int lat, input int stray, input int rprob, input bit late);
        reqProb[0] = p0;
        reqProb[1] = p1;
        fixAddr[0] = a0;
        fixAddr[1] = a1;
        forceLat   = lat;
        strayProb  = stray;
        resetProb  = rprob;
        lateInject = late;
    endtask

    task automatic applyStimulus();
        bit busyE, inWindow, doReset;
        int w, lat;

        busyE    = (readCyc >= 0) && (cyc >= readCyc) && (cyc < respCyc);
        inWindow = (readCyc >= 0) && (cyc > readCyc) && (cyc < respCyc);
        if (cyc == respCyc) lastData = expData;

        checkOutput("gnt0",    32'(gnt0),    32'((cyc == readCyc) && (winner == 0)));
        checkOutput("gnt1",    32'(gnt1),    32'((cyc == readCyc) && (winner == 1)));
        checkOutput("romRead", 32'(romRead), 32'(cyc == readCyc));
        checkOutput("busy",    32'(busy),    32'(busyE));
        checkOutput("valid0",  32'(valid0),  32'((cyc == respCyc) && (winner == 0)));
        checkOutput("valid1",  32'(valid1),  32'((cyc == respCyc) && (winner == 1)));
        checkOutput("err",     32'(err),     32'((cyc == respCyc) && expErr));
        checkOutput("data",    32'(data),    32'(lastData));
        if (busyE) checkOutput("romAddress", 32'(romAddress), 32'(wAddr));
        if (addrZeroCheck) begin
            checkOutput("romAddressReset", 32'(romAddress), 32'd0);
            addrZeroCheck = 1'b0;
        end

        doReset = (resetProb > 0) &&
                  ((int'($urandom_range(0, 999)) < resetProb) ||
                   (inWindow && waitResets == 0 && cyc >= 400));

        if (doReset) begin
            if (inWindow) waitResets++;
            rst           = 1'b1;
            quietUntil    = (romValidCyc + 1 > cyc + 1) ? romValidCyc + 1 : cyc + 1;
            readCyc       = -1;
            respCyc       = -1;
            rr            = 0;
            lastData      = '0;
            active[0]     = 1'b0;
            active[1]     = 1'b0;
            freeAt        = cyc + 1;
            addrZeroCheck = 1'b1;
        end else begin
            rst = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (active[p] && readCyc >= 0 && readCyc == cyc - 1 && winner == p) active[p] = 1'b0;
                if (!active[p] && cyc >= quietUntil && int'($urandom_range(0, 99)) < reqProb[p]) begin
                    active[p]  = 1'b1;
                    reqAddr[p] = (fixAddr[p] >= 0) ? 9'(fixAddr[p]) : 9'($urandom_range(0, 511));
                end
            end
            if (cyc >= freeAt && (active[0] || active[1])) begin
                w            = (active[0] && active[1]) ? rr : (active[1] ? 1 : 0);
                rr           = 1 - w;
                winner       = w;
                wAddr        = reqAddr[w];
                readCyc      = cyc + 1;
                lateValidCyc = -1;
                if (forceLat == 0 || (forceLat < 0 && int'($urandom_range(0, 99)) < 12)) begin
                    respCyc     = cyc + 2 + TIMEOUT;
                    romValidCyc = -1;
                    expData     = '0;
                    expErr      = 1'b1;
                    if (lateInject) begin
                        lateValidCyc = cyc + 20;
                        quietUntil   = cyc + 21;
                    end
                end else begin
                    lat         = (forceLat > 0) ? forceLat : pickLat();
                    romValidCyc = cyc + 1 + lat;
                    respCyc     = cyc + 2 + lat;
                    expData     = romWord(wAddr);
                    expErr      = 1'b0;
                end
                freeAt = respCyc;
            end
        end

        req0  = active[0];
        req1  = active[1];
        addr0 = reqAddr[0];
        addr1 = reqAddr[1];
        if (cyc == romValidCyc) begin
            romValid = 1'b1;
            romData  = romWord(wAddr);
        end else if (cyc == lateValidCyc || (!inWindow && int'($urandom_range(0, 99)) < strayProb)) begin
            romValid = 1'b1;
            romData  = 24'($urandom);
        end else begin
            romValid = 1'b0;
            romData  = 24'($urandom);
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rr = 0; freeAt = 0; winner = 0; readCyc = -1; respCyc = -1;
        romValidCyc = -1; lateValidCyc = -1; quietUntil = 0; waitResets = 0;
        wAddr = '0; expData = '0; lastData = '0; expErr = 1'b0; addrZeroCheck = 1'b1;
        active[0] = 1'b0; active[1] = 1'b0; reqAddr[0] = '0; reqAddr[1] = '0;
        setPhase(0, 0, -1, -1, -1, 0, 0, 1'b0);

        @(posedge clk);
        #1;
        cyc = 0;

        // Single port-0 request, ROM latency 1.
        setPhase(100, 0, 'h015, -1, 1, 0, 0, 1'b0);
        applyStimulus();
        setPhase(0, 0, -1, -1, 1, 0, 0, 1'b0);
        repeat (6) applyStimulus();

        // Both ports requesting continuously, fixed addresses, latency 2.
        setPhase(100, 100, 'h001, 'h002, 2, 0, 0, 1'b0);
        repeat (24) applyStimulus();
        setPhase(0, 0, -1, -1, 2, 0, 0, 1'b0);
        repeat (12) applyStimulus();

        // Lone requester, then both at once.
        setPhase(100, 0, -1, -1, 3, 0, 0, 1'b0);
        applyStimulus();
        setPhase(0, 0, -1, -1, 3, 0, 0, 1'b0);
        repeat (8) applyStimulus();
        setPhase(100, 100, -1, -1, 3, 0, 0, 1'b0);
        applyStimulus();
        setPhase(0, 0, -1, -1, 3, 0, 0, 1'b0);
        repeat (14) applyStimulus();

        // Timeout on port 1 with a late ROM valid three cycles after the error response.
        setPhase(0, 100, -1, 'h0AB, 0, 0, 0, 1'b1);
        applyStimulus();
        setPhase(0, 0, -1, -1, 0, 0, 0, 1'b0);
        repeat (26) applyStimulus();

        // Random traffic with stray ROM valids and occasional resets.
        setPhase(30, 30, -1, -1, -1, 5, 4, 1'b0);
        repeat (3000) applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
